sampled_edge_monitor: RTL and testbench

//  Downstream consumer of a free-running stimulus signal such as a clock-rate toggling bit.

---
 rtl/sampled_mon_pkg.sv | 16 +
 rtl/sampled_edge_monitor_sat_counter.sv | 20 ++
 rtl/sampled_edge_monitor.sv | 113 +++++++++++
 tb/tb_sampled_edge_monitor.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sampled_mon_pkg.sv
// Shared types and default parameter values for sampled_edge_monitor.
// FSM state encoding lives here so checkers can decode it.
package sampled_mon_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    STUCK = 2'd2
  } mon_state_e;

  localparam int DEF_WIDTH       = 1;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_STALL_LIMIT = 4;
  localparam int DEF_PAST_DEPTH  = 4;

endpackage

// File: rtl/sampled_edge_monitor_sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones, clr has priority.
// Latency 1; no backpressure.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/sampled_edge_monitor.sv
// Registered rose/fell/stable flags, saturating toggle count and stuck detector on sampled din.
// Latency 1 enabled sample; en=0 freezes state. Optional past_q history under `PAST_HISTORY_EN.
module sampled_edge_monitor
  import sampled_mon_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int STALL_LIMIT = DEF_STALL_LIMIT,
  parameter int PAST_DEPTH  = DEF_PAST_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr_cnt,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rose,
  output logic [WIDTH-1:0] fell,
  output logic             stable,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             stuck,
  output logic [WIDTH-1:0] past_q
);

  localparam int               RUN_W   = $clog2(STALL_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_LIMIT);
  localparam logic [RUN_W-1:0] RUN_PRE = RUN_W'(STALL_LIMIT - 1);

  mon_state_e       state;
  logic [WIDTH-1:0] prev;
  logic [RUN_W-1:0] run;
  logic             cmp;
  logic             changed;
  logic             tog_inc;
  logic             run_inc;
  logic             run_clr;

  // A compare only exists once a previous enabled sample has been captured.
  assign cmp     = en && (state != INIT);
  assign changed = (din != prev);
  assign tog_inc = cmp && changed;
  assign run_inc = cmp && !changed && (run != RUN_MAX);
  assign run_clr = rst || (cmp && changed);

  sat_counter #(.W(CNT_W)) u_toggle_cnt (
    .clk (clk),
    .inc (tog_inc),
    .clr (rst || clr_cnt),
    .q   (toggle_cnt)
  );

  sat_counter #(.W(RUN_W)) u_run_cnt (
    .clk (clk),
    .inc (run_inc),
    .clr (run_clr),
    .q   (run)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= INIT;
      prev   <= '0;
      rose   <= '0;
      fell   <= '0;
      stable <= 1'b0;
      stuck  <= 1'b0;
    end else if (!en) begin
      rose   <= '0;
      fell   <= '0;
      stable <= 1'b0;
    end else begin
      prev <= din;
      case (state)
        INIT: begin
          state  <= TRACK;
          rose   <= '0;
          fell   <= '0;
          stable <= 1'b0;
        end
        default: begin
          rose   <= din & ~prev;
          fell   <= ~din & prev;
          stable <= !changed;
          if (changed) begin
            state <= TRACK;
            stuck <= 1'b0;
          end else if ((state == TRACK) && (run == RUN_PRE)) begin
            // run reaches STALL_LIMIT on this same update
            state <= STUCK;
            stuck <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef PAST_HISTORY_EN
  logic [WIDTH-1:0] hist [PAST_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PAST_DEPTH; i++) hist[i] <= '0;
    end else if (en) begin
      hist[0] <= din;
      for (int i = 1; i < PAST_DEPTH; i++) hist[i] <= hist[i-1];
    end
  end

  assign past_q = hist[PAST_DEPTH-1];
`else
  assign past_q = '0;
`endif

endmodule

// File: tb/tb_sampled_edge_monitor.sv
// Bench for sampled_edge_monitor: hand-derived vector table, directed corner sequences,
// and randomized stimulus checked against a sample-history reference model.
module tb_sampled_edge_monitor;

  localparam int W       = 2;
  localparam int CW      = 4;
  localparam int SL      = 4;
  localparam int PD      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          clr_cnt = 1'b0;
  logic [W-1:0]  din = '0;
  logic [W-1:0]  rose, fell, past_q;
  logic          stable, stuck;
  logic [CW-1:0] toggle_cnt;

  always #5 clk = ~clk;

  sampled_edge_monitor #(
    .WIDTH(W), .CNT_W(CW), .STALL_LIMIT(SL), .PAST_DEPTH(PD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr_cnt    (clr_cnt),
    .din        (din),
    .rose       (rose),
    .fell       (fell),
    .stable     (stable),
    .toggle_cnt (toggle_cnt),
    .stuck      (stuck),
    .past_q     (past_q)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: list of enabled samples since reset plus derived outputs.
  logic [W-1:0] hist[$];
  int           m_cnt = 0;
  logic         m_stuck = 1'b0;
  logic [W-1:0] m_rose = '0, m_fell = '0;
  logic         m_stable = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int trailing_equal();
    int k = 0;
    for (int i = hist.size() - 1; i > 0; i--) begin
      if (hist[i] != hist[i-1] || k >= SL) break;
      k++;
    end
    return k;
  endfunction

  function automatic int exp_past();
`ifdef PAST_HISTORY_EN
    if (hist.size() >= PD) return int'(hist[hist.size() - PD]);
`endif
    return 0;
  endfunction

  task automatic model_step(input logic r, input logic e, input logic c, input logic [W-1:0] d);
    logic [W-1:0] p;
    m_rose = '0; m_fell = '0; m_stable = 1'b0;
    if (r) begin
      hist.delete();
      m_cnt = 0;
      m_stuck = 1'b0;
    end else begin
      if (e) begin
        if (hist.size() > 0) begin
          p = hist[hist.size() - 1];
          m_rose   = d & ~p;
          m_fell   = ~d & p;
          m_stable = (d == p);
          if (d != p && m_cnt < CNT_MAX) m_cnt++;
        end
        hist.push_back(d);
        m_stuck = (trailing_equal() >= SL);
      end
      if (c) m_cnt = 0;
    end
  endtask

  task automatic apply(input logic r, input logic e, input logic c, input logic [W-1:0] d);
    rst = r; en = e; clr_cnt = c; din = d;
    @(posedge clk);
    #1;
    model_step(r, e, c, d);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".rose"},   int'(rose),       int'(m_rose));
    check({tag, ".fell"},   int'(fell),       int'(m_fell));
    check({tag, ".stable"}, int'(stable),     int'(m_stable));
    check({tag, ".cnt"},    int'(toggle_cnt), m_cnt);
    check({tag, ".stuck"},  int'(stuck),      int'(m_stuck));
    check({tag, ".past"},   int'(past_q),     exp_past());
  endtask

  task automatic step(input string tag, input logic r, input logic e, input logic c,
                      input logic [W-1:0] d);
    apply(r, e, c, d);
    check_model(tag);
  endtask

  typedef struct {
    logic         r, e, c;
    logic [W-1:0] d;
    logic [W-1:0] xr, xf;
    logic         xs;
    int           xcnt;
    logic         xstk;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [W-1:0] cur;
    logic r, e, c;

    // rst en clr din | rose fell stable cnt stuck
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 2'b10, 2'b10, 2'b01, 1'b0, 1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 2'b01, 2'b01, 2'b10, 1'b0, 2, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 2'b10, 2'b10, 2'b01, 1'b0, 3, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 2'b11, 2'b01, 2'b00, 1'b0, 4, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 4, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 4, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 4, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 4, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 4, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 2'b10, 1'b0, 5, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 5, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 0, 1'b0};

    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].r, tbl[i].e, tbl[i].c, tbl[i].d);
      check($sformatf("tbl%0d.rose", i),   int'(rose),       int'(tbl[i].xr));
      check($sformatf("tbl%0d.fell", i),   int'(fell),       int'(tbl[i].xf));
      check($sformatf("tbl%0d.stable", i), int'(stable),     int'(tbl[i].xs));
      check($sformatf("tbl%0d.cnt", i),    int'(toggle_cnt), tbl[i].xcnt);
      check($sformatf("tbl%0d.stuck", i),  int'(stuck),      int'(tbl[i].xstk));
      check($sformatf("tbl%0d.past", i),   int'(past_q),     exp_past());
    end

    // Toggle count saturation, then clear colliding with a toggle.
    step("sat.rst", 1'b1, 1'b0, 1'b0, 2'b00);
    cur = 2'b01;
    for (int i = 0; i < 20; i++) begin
      step("sat", 1'b0, 1'b1, 1'b0, cur);
      cur = ~cur;
    end
    check("sat.cnt15", int'(toggle_cnt), 15);
    step("sat.clr", 1'b0, 1'b1, 1'b1, cur);
    check("sat.clr0", int'(toggle_cnt), 0);

    // en=0 while din toggles: flags drop, state holds, compare resumes vs last enabled sample.
    step("hold.a", 1'b0, 1'b1, 1'b0, 2'b10);
    for (int i = 0; i < 3; i++) step("hold.off", 1'b0, 1'b0, 1'b0, (i % 2 == 0) ? 2'b01 : 2'b10);
    step("hold.on", 1'b0, 1'b1, 1'b0, 2'b10);
    check("hold.stable", int'(stable), 1);

    // Reach STUCK with toggle_cnt=7, then reset.
    step("stk.rst", 1'b1, 1'b0, 1'b0, 2'b00);
    step("stk.init", 1'b0, 1'b1, 1'b0, 2'b01);
    cur = 2'b10;
    for (int i = 0; i < 7; i++) begin
      step("stk.tog", 1'b0, 1'b1, 1'b0, cur);
      cur = ~cur;
    end
    cur = ~cur;
    for (int i = 0; i < 4; i++) step("stk.hold", 1'b0, 1'b1, 1'b0, cur);
    check("stk.stuck", int'(stuck), 1);
    check("stk.cnt7", int'(toggle_cnt), 7);
    step("stk.reset", 1'b1, 1'b1, 1'b0, ~cur);
    check("stk.rst_stuck", int'(stuck), 0);
    check("stk.rst_cnt", int'(toggle_cnt), 0);
    step("stk.first", 1'b0, 1'b1, 1'b0, ~cur);
    check("stk.first_stable", int'(stable), 0);

    // History: din = 1,0,0,1,1 on bit 0.
    step("past.rst", 1'b1, 1'b0, 1'b0, 2'b00);
    step("past0", 1'b0, 1'b1, 1'b0, 2'b01);
    step("past1", 1'b0, 1'b1, 1'b0, 2'b00);
    step("past2", 1'b0, 1'b1, 1'b0, 2'b00);
    step("past3", 1'b0, 1'b1, 1'b0, 2'b01);
`ifdef PAST_HISTORY_EN
    check("past.first", int'(past_q), 1);
`else
    check("past.off", int'(past_q), 0);
`endif
    step("past4", 1'b0, 1'b1, 1'b0, 2'b01);

    // Randomized: sticky din so stuck is reached regularly.
    cur = 2'b00;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) cur = W'($urandom_range(0, (1 << W) - 1));
      r = ($urandom_range(0, 99) < 2);
      e = ($urandom_range(0, 99) < 75);
      c = ($urandom_range(0, 99) < 4);
      step("rnd", r, e, c, cur);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
